// File: rtl/dc_mcl_pkg.sv
// Shared types for the MCL configuration receiver: field widths, the
// configuration bundle struct, the receiver state and the clip helper.
package dc_mcl_pkg;

  localparam int SCR_SIZE_WIDTH     = 12;
  localparam int AXI_ARADDR_WIDTH   = 32;
  localparam int RGB_WIDTH          = 24;
  localparam int SCALE_METHOD_WIDTH = 2;

  // One complete configuration bundle, as seen on conf_* and act_*.
  typedef struct packed {
    logic [SCR_SIZE_WIDTH-1:0]     screen_width;
    logic [SCR_SIZE_WIDTH-1:0]     screen_height;
    logic [SCR_SIZE_WIDTH-1:0]     tex_width;
    logic [SCR_SIZE_WIDTH-1:0]     tex_height;
    logic [SCR_SIZE_WIDTH-1:0]     image_width;
    logic [SCR_SIZE_WIDTH-1:0]     image_height;
    logic [SCR_SIZE_WIDTH-1:0]     image_offset_x;
    logic [SCR_SIZE_WIDTH-1:0]     image_offset_y;
    logic [SCALE_METHOD_WIDTH-1:0] scale_method;
    logic [RGB_WIDTH-1:0]          border_color;
    logic [AXI_ARADDR_WIDTH-1:0]   tex_address;
  } conf_t;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PENDING = 1'b1
  } rx_state_e;

  // Clamp a widened (offset + length) sum to the screen limit.
  function automatic logic [SCR_SIZE_WIDTH-1:0] clip_end(
    input logic [SCR_SIZE_WIDTH:0]   sum,
    input logic [SCR_SIZE_WIDTH-1:0] lim
  );
    logic [SCR_SIZE_WIDTH-1:0] res;
    if (sum < {1'b0, lim}) begin
      res = sum[SCR_SIZE_WIDTH-1:0];
    end else begin
      res = lim;
    end
    return res;
  endfunction

endpackage

// File: rtl/dc_mcl_conf_window_calc.sv
// Combinational layer-window clip and visibility for one configuration.
// The end coordinates are exclusive; an invisible layer reports the full
// screen as its end so downstream comparators stay well defined.
module dc_mcl_conf_window_calc
  import dc_mcl_pkg::*;
(
  input  logic [SCR_SIZE_WIDTH-1:0] screen_width_i,
  input  logic [SCR_SIZE_WIDTH-1:0] screen_height_i,
  input  logic [SCR_SIZE_WIDTH-1:0] image_width_i,
  input  logic [SCR_SIZE_WIDTH-1:0] image_height_i,
  input  logic [SCR_SIZE_WIDTH-1:0] image_offset_x_i,
  input  logic [SCR_SIZE_WIDTH-1:0] image_offset_y_i,
  output logic [SCR_SIZE_WIDTH-1:0] end_x_o,
  output logic [SCR_SIZE_WIDTH-1:0] end_y_o,
  output logic                      visible_o
);

  logic [SCR_SIZE_WIDTH:0] sum_x_s;
  logic [SCR_SIZE_WIDTH:0] sum_y_s;

  // Widened sums avoid wrap-around, then clip against the screen.
  always_comb begin
    sum_x_s   = {1'b0, image_offset_x_i} + {1'b0, image_width_i};
    sum_y_s   = {1'b0, image_offset_y_i} + {1'b0, image_height_i};
    visible_o = (image_offset_x_i < screen_width_i) &&
                (image_offset_y_i < screen_height_i) &&
                (image_width_i  != {SCR_SIZE_WIDTH{1'b0}}) &&
                (image_height_i != {SCR_SIZE_WIDTH{1'b0}});
    if (visible_o) begin
      end_x_o = clip_end(sum_x_s, screen_width_i);
      end_y_o = clip_end(sum_y_s, screen_height_i);
    end else begin
      end_x_o = screen_width_i;
      end_y_o = screen_height_i;
    end
  end

endmodule

// File: rtl/dc_mcl_conf_receiver.sv
// Consumer end of the MCL configuration interface. A bundle is held in a
// pending set and promoted to the active set only on frame_start, so the
// display pipeline never sees a configuration change mid-frame. A bundle
// arriving together with frame_start bypasses the pending set.
module dc_mcl_conf_receiver
  import dc_mcl_pkg::*;
(
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          en,
  input  logic                          conf_valid,
  output logic                          conf_ready,
  input  logic [SCR_SIZE_WIDTH-1:0]     conf_screen_width,
  input  logic [SCR_SIZE_WIDTH-1:0]     conf_screen_height,
  input  logic [SCR_SIZE_WIDTH-1:0]     conf_tex_width,
  input  logic [SCR_SIZE_WIDTH-1:0]     conf_tex_height,
  input  logic [SCR_SIZE_WIDTH-1:0]     conf_image_width,
  input  logic [SCR_SIZE_WIDTH-1:0]     conf_image_height,
  input  logic [SCR_SIZE_WIDTH-1:0]     conf_image_offset_x,
  input  logic [SCR_SIZE_WIDTH-1:0]     conf_image_offset_y,
  input  logic [SCALE_METHOD_WIDTH-1:0] conf_scale_method,
  input  logic [RGB_WIDTH-1:0]          conf_border_color,
  input  logic [AXI_ARADDR_WIDTH-1:0]   conf_tex_address,
  input  logic                          frame_start,
  output logic [SCR_SIZE_WIDTH-1:0]     act_screen_width,
  output logic [SCR_SIZE_WIDTH-1:0]     act_screen_height,
  output logic [SCR_SIZE_WIDTH-1:0]     act_tex_width,
  output logic [SCR_SIZE_WIDTH-1:0]     act_tex_height,
  output logic [SCR_SIZE_WIDTH-1:0]     act_image_width,
  output logic [SCR_SIZE_WIDTH-1:0]     act_image_height,
  output logic [SCR_SIZE_WIDTH-1:0]     act_image_offset_x,
  output logic [SCR_SIZE_WIDTH-1:0]     act_image_offset_y,
  output logic [SCALE_METHOD_WIDTH-1:0] act_scale_method,
  output logic [RGB_WIDTH-1:0]          act_border_color,
  output logic [AXI_ARADDR_WIDTH-1:0]   act_tex_address,
  output logic [SCR_SIZE_WIDTH-1:0]     act_win_end_x,
  output logic [SCR_SIZE_WIDTH-1:0]     act_win_end_y,
  output logic                          act_visible,
  output logic                          act_valid,
  output logic                          conf_applied,
  output logic                          conf_dropped
);

  conf_t     conf_in_s;
  conf_t     load_src_s;
  conf_t     pend_q, pend_d;
  conf_t     act_q;
  rx_state_e state_q, state_d;

  logic                      conf_ready_q;
  logic                      act_valid_q;
  logic                      conf_applied_q;
  logic                      conf_dropped_q;
  logic                      act_visible_q;
  logic [SCR_SIZE_WIDTH-1:0] win_end_x_q;
  logic [SCR_SIZE_WIDTH-1:0] win_end_y_q;

  logic                      xfer_s;
  logic                      bypass_s;
  logic                      promote_s;
  logic                      load_s;
  logic                      drop_set_s;
  logic [SCR_SIZE_WIDTH-1:0] calc_end_x_s;
  logic [SCR_SIZE_WIDTH-1:0] calc_end_y_s;
  logic                      calc_visible_s;

  assign conf_in_s = '{
    screen_width:   conf_screen_width,
    screen_height:  conf_screen_height,
    tex_width:      conf_tex_width,
    tex_height:     conf_tex_height,
    image_width:    conf_image_width,
    image_height:   conf_image_height,
    image_offset_x: conf_image_offset_x,
    image_offset_y: conf_image_offset_y,
    scale_method:   conf_scale_method,
    border_color:   conf_border_color,
    tex_address:    conf_tex_address
  };

  // Next-state, pending capture and active-load decisions.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    bypass_s   = 1'b0;
    promote_s  = 1'b0;
    xfer_s     = en && conf_valid && conf_ready_q;
    // Only reachable if ready and state ever disagree (en-toggle corner).
    drop_set_s = en && frame_start && (state_q == ST_EMPTY) &&
                 conf_valid && !conf_ready_q;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_s && frame_start) begin
          bypass_s = 1'b1;
        end else if (xfer_s) begin
          pend_d  = conf_in_s;
          state_d = ST_PENDING;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_PENDING: begin
        if (en && frame_start) begin
          promote_s = 1'b1;
          state_d   = ST_EMPTY;
        end else begin
          state_d   = ST_PENDING;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
    load_s     = bypass_s || promote_s;
    load_src_s = bypass_s ? conf_in_s : pend_q;
  end

  dc_mcl_conf_window_calc u_window_calc (
    .screen_width_i   (load_src_s.screen_width),
    .screen_height_i  (load_src_s.screen_height),
    .image_width_i    (load_src_s.image_width),
    .image_height_i   (load_src_s.image_height),
    .image_offset_x_i (load_src_s.image_offset_x),
    .image_offset_y_i (load_src_s.image_offset_y),
    .end_x_o          (calc_end_x_s),
    .end_y_o          (calc_end_y_s),
    .visible_o        (calc_visible_s)
  );

  // State, pending and active registers; everything but the apply pulse holds while en is low.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= ST_EMPTY;
      pend_q         <= '0;
      act_q          <= '0;
      conf_ready_q   <= 1'b1;
      act_valid_q    <= 1'b0;
      conf_applied_q <= 1'b0;
      conf_dropped_q <= 1'b0;
      act_visible_q  <= 1'b0;
      win_end_x_q    <= {SCR_SIZE_WIDTH{1'b0}};
      win_end_y_q    <= {SCR_SIZE_WIDTH{1'b0}};
    end else begin
      conf_applied_q <= load_s;
      if (en) begin
        state_q      <= state_d;
        pend_q       <= pend_d;
        conf_ready_q <= (state_d == ST_EMPTY);
        if (load_s) begin
          act_q         <= load_src_s;
          win_end_x_q   <= calc_end_x_s;
          win_end_y_q   <= calc_end_y_s;
          act_visible_q <= calc_visible_s;
          act_valid_q   <= 1'b1;
        end
        if (drop_set_s) begin
          conf_dropped_q <= 1'b1;
        end
      end
    end
  end

  assign conf_ready         = conf_ready_q;
  assign act_screen_width   = act_q.screen_width;
  assign act_screen_height  = act_q.screen_height;
  assign act_tex_width      = act_q.tex_width;
  assign act_tex_height     = act_q.tex_height;
  assign act_image_width    = act_q.image_width;
  assign act_image_height   = act_q.image_height;
  assign act_image_offset_x = act_q.image_offset_x;
  assign act_image_offset_y = act_q.image_offset_y;
  assign act_scale_method   = act_q.scale_method;
  assign act_border_color   = act_q.border_color;
  assign act_tex_address    = act_q.tex_address;
  assign act_win_end_x      = win_end_x_q;
  assign act_win_end_y      = win_end_y_q;
  assign act_visible        = act_visible_q;
  assign act_valid          = act_valid_q;
  assign conf_applied       = conf_applied_q;
  assign conf_dropped       = conf_dropped_q;

endmodule

// File: tb/tb_dc_mcl_conf_receiver.sv
// Self-checking bench for dc_mcl_conf_receiver: directed scenarios plus a
// randomized run, all checked against a small transaction-level model.
module tb_dc_mcl_conf_receiver;

  typedef struct packed {
    logic [11:0] sw, sh, tw, th, iw, ih, ox, oy;
    logic [1:0]  sm;
    logic [23:0] bc;
    logic [31:0] ta;
  } tcfg_t;

  logic clk, nrst, en, conf_valid, frame_start;
  tcfg_t drv;
  logic conf_ready, act_visible, act_valid, conf_applied, conf_dropped;
  logic [11:0] act_screen_width, act_screen_height, act_tex_width, act_tex_height;
  logic [11:0] act_image_width, act_image_height, act_image_offset_x, act_image_offset_y;
  logic [1:0]  act_scale_method;
  logic [23:0] act_border_color;
  logic [31:0] act_tex_address;
  logic [11:0] act_win_end_x, act_win_end_y;
  tcfg_t act_all;

  assign act_all = {act_screen_width, act_screen_height, act_tex_width, act_tex_height,
                    act_image_width, act_image_height, act_image_offset_x, act_image_offset_y,
                    act_scale_method, act_border_color, act_tex_address};

  int n_checks = 0;
  int n_errors = 0;

  // Model: what the display side should see, by transaction.
  tcfg_t m_act, m_pend;
  bit    m_has_pend, m_valid, m_applied;

  dc_mcl_conf_receiver dut (
    .clk(clk), .nrst(nrst), .en(en), .conf_valid(conf_valid), .conf_ready(conf_ready),
    .conf_screen_width(drv.sw), .conf_screen_height(drv.sh),
    .conf_tex_width(drv.tw), .conf_tex_height(drv.th),
    .conf_image_width(drv.iw), .conf_image_height(drv.ih),
    .conf_image_offset_x(drv.ox), .conf_image_offset_y(drv.oy),
    .conf_scale_method(drv.sm), .conf_border_color(drv.bc), .conf_tex_address(drv.ta),
    .frame_start(frame_start),
    .act_screen_width(act_screen_width), .act_screen_height(act_screen_height),
    .act_tex_width(act_tex_width), .act_tex_height(act_tex_height),
    .act_image_width(act_image_width), .act_image_height(act_image_height),
    .act_image_offset_x(act_image_offset_x), .act_image_offset_y(act_image_offset_y),
    .act_scale_method(act_scale_method), .act_border_color(act_border_color),
    .act_tex_address(act_tex_address),
    .act_win_end_x(act_win_end_x), .act_win_end_y(act_win_end_y),
    .act_visible(act_visible), .act_valid(act_valid),
    .conf_applied(conf_applied), .conf_dropped(conf_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_vis(tcfg_t c);
    return (int'(c.ox) < int'(c.sw)) && (int'(c.oy) < int'(c.sh)) && (c.iw != 12'd0) && (c.ih != 12'd0);
  endfunction

  function automatic logic [11:0] exp_end(int off, int len, int lim, bit vis);
    if (!vis) return 12'(lim);
    return 12'(((off + len) < lim) ? (off + len) : lim);
  endfunction

  function automatic tcfg_t plan_cfg(int iw, int ih, int ox, int oy);
    tcfg_t c;
    c.sw = 12'd1280; c.sh = 12'd720; c.tw = 12'd320; c.th = 12'd240;
    c.iw = 12'(iw); c.ih = 12'(ih); c.ox = 12'(ox); c.oy = 12'(oy);
    c.sm = 2'($urandom_range(0, 3));
    c.bc = 24'($urandom);
    c.ta = $urandom;
    return c;
  endfunction

  task automatic model_reset();
    m_act = '0; m_pend = '0; m_has_pend = 1'b0; m_valid = 1'b0; m_applied = 1'b0;
  endtask

  // Advance the model on the inputs currently driven, then clock and settle.
  task automatic step();
    m_applied = 1'b0;
    if (en) begin
      if (!m_has_pend) begin
        if (conf_valid && frame_start) begin
          m_act = drv; m_valid = 1'b1; m_applied = 1'b1;
        end else if (conf_valid) begin
          m_pend = drv; m_has_pend = 1'b1;
        end
      end else if (frame_start) begin
        m_act = m_pend; m_has_pend = 1'b0; m_valid = 1'b1; m_applied = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b1; conf_valid = 1'b0; frame_start = 1'b0;
    drv = plan_cfg(0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 nrst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++; if (conf_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready cyc %0d got=%0d exp=1", i, conf_ready); end
      n_checks++; if (act_valid !== 1'b0) begin n_errors++; $display("FAIL reset_act_valid got=%0d exp=0", act_valid); end
      n_checks++; if (conf_applied !== 1'b0) begin n_errors++; $display("FAIL reset_applied got=%0d exp=0", conf_applied); end
      n_checks++; if (act_all !== '0) begin n_errors++; $display("FAIL reset_act got=%h exp=0", act_all); end
      n_checks++; if ({act_win_end_x, act_win_end_y, act_visible, conf_dropped} !== 26'd0) begin n_errors++;
        $display("FAIL reset_win got=%0d,%0d vis=%0d drop=%0d exp=0", act_win_end_x, act_win_end_y, act_visible, conf_dropped); end
    end
  endtask

  task automatic test_pending_apply();
    drv = plan_cfg(640, 480, 320, 120);
    conf_valid = 1'b1; step(); conf_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (conf_ready !== 1'b0) begin n_errors++; $display("FAIL pend_ready cyc %0d got=%0d exp=0", i, conf_ready); end
      n_checks++; if (act_image_width !== 12'd0 || conf_applied !== 1'b0) begin n_errors++;
        $display("FAIL pend_early got iw=%0d applied=%0d exp iw=0 applied=0", act_image_width, conf_applied); end
      if (i < 4) step();
    end
    frame_start = 1'b1; step(); frame_start = 1'b0;
    n_checks++; if (act_image_width !== 12'd640) begin n_errors++; $display("FAIL pend_iw got=%0d exp=640", act_image_width); end
    n_checks++; if (act_win_end_x !== 12'd960 || act_win_end_y !== 12'd600) begin n_errors++;
      $display("FAIL pend_end got=%0d,%0d exp=960,600", act_win_end_x, act_win_end_y); end
    n_checks++; if (act_visible !== 1'b1 || act_valid !== 1'b1) begin n_errors++;
      $display("FAIL pend_vis got vis=%0d valid=%0d exp 1,1", act_visible, act_valid); end
    n_checks++; if (conf_applied !== 1'b1) begin n_errors++; $display("FAIL pend_applied got=%0d exp=1", conf_applied); end
    n_checks++; if (conf_ready !== 1'b1) begin n_errors++; $display("FAIL pend_ready_back got=%0d exp=1", conf_ready); end
    n_checks++; if (act_all !== m_act) begin n_errors++; $display("FAIL pend_act got=%h exp=%h", act_all, m_act); end
    step();
    n_checks++; if (conf_applied !== 1'b0) begin n_errors++; $display("FAIL pend_pulse_len got=%0d exp=0", conf_applied); end
  endtask

  task automatic test_bypass_and_clip();
    int cases[6][4] = '{'{1280, 720, 0, 0}, '{320, 240, 1600, 1200}, '{640, 480, 1100, 600},
                        '{0, 100, 10, 10}, '{100, 100, 1279, 719}, '{100, 100, 1280, 0}};
    for (int k = 0; k < 6; k++) begin
      tcfg_t c;
      bit v;
      c = plan_cfg(cases[k][0], cases[k][1], cases[k][2], cases[k][3]);
      v = exp_vis(c);
      drv = c; conf_valid = 1'b1; frame_start = 1'b1;
      step();
      n_checks++; if (conf_ready !== 1'b1) begin n_errors++; $display("FAIL byp_ready case %0d got=%0d exp=1", k, conf_ready); end
      n_checks++; if (act_all !== c || conf_applied !== 1'b1) begin n_errors++;
        $display("FAIL byp_act case %0d got=%h applied=%0d exp=%h applied=1", k, act_all, conf_applied, c); end
      n_checks++; if (act_visible !== v) begin n_errors++; $display("FAIL byp_vis case %0d got=%0d exp=%0d", k, act_visible, v); end
      n_checks++; if (act_win_end_x !== exp_end(int'(c.ox), int'(c.iw), int'(c.sw), v) ||
                      act_win_end_y !== exp_end(int'(c.oy), int'(c.ih), int'(c.sh), v)) begin n_errors++;
        $display("FAIL byp_end case %0d got=%0d,%0d exp=%0d,%0d", k, act_win_end_x, act_win_end_y,
                 exp_end(int'(c.ox), int'(c.iw), int'(c.sw), v), exp_end(int'(c.oy), int'(c.ih), int'(c.sh), v)); end
    end
    conf_valid = 1'b0; frame_start = 1'b0; step();
    n_checks++; if (conf_ready !== 1'b1 || conf_applied !== 1'b0) begin n_errors++;
      $display("FAIL byp_after got ready=%0d applied=%0d exp 1,0", conf_ready, conf_applied); end
  endtask

  task automatic test_hold_while_pending();
    tcfg_t a, b;
    a = plan_cfg(200, 100, 50, 60);
    b = plan_cfg(300, 150, 70, 80);
    drv = a; conf_valid = 1'b1; step();
    drv = b;
    repeat (3) step();
    n_checks++; if (conf_ready !== 1'b0) begin n_errors++; $display("FAIL hold_ready got=%0d exp=0", conf_ready); end
    frame_start = 1'b1; step(); frame_start = 1'b0;
    n_checks++; if (act_all !== a) begin n_errors++; $display("FAIL hold_first got=%h exp=%h", act_all, a); end
    n_checks++; if (conf_ready !== 1'b1) begin n_errors++; $display("FAIL hold_ready_back got=%0d exp=1", conf_ready); end
    step(); conf_valid = 1'b0;
    n_checks++; if (conf_ready !== 1'b0) begin n_errors++; $display("FAIL hold_second_accept got ready=%0d exp=0", conf_ready); end
    frame_start = 1'b1; step(); frame_start = 1'b0;
    n_checks++; if (act_all !== b) begin n_errors++; $display("FAIL hold_second got=%h exp=%h", act_all, b); end
    n_checks++; if (conf_dropped !== 1'b0) begin n_errors++; $display("FAIL hold_dropped got=%0d exp=0", conf_dropped); end
  endtask

  task automatic test_enable_and_async_reset();
    tcfg_t old_act;
    old_act = m_act;
    drv = plan_cfg(400, 300, 10, 20);
    conf_valid = 1'b1; step(); conf_valid = 1'b0;
    en = 1'b0; frame_start = 1'b1;
    repeat (2) step();
    n_checks++; if (conf_applied !== 1'b0 || act_all !== old_act) begin n_errors++;
      $display("FAIL en_hold got applied=%0d act=%h exp applied=0 act=%h", conf_applied, act_all, old_act); end
    n_checks++; if (conf_ready !== 1'b0) begin n_errors++; $display("FAIL en_ready got=%0d exp=0", conf_ready); end
    en = 1'b1; frame_start = 1'b0; step();
    #3 nrst = 1'b0;
    #1;
    n_checks++; if (conf_ready !== 1'b1 || act_valid !== 1'b0 || act_all !== '0 || act_visible !== 1'b0) begin n_errors++;
      $display("FAIL arst_now got ready=%0d valid=%0d act=%h vis=%0d exp 1,0,0,0", conf_ready, act_valid, act_all, act_visible); end
    #2 nrst = 1'b1;
    model_reset();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    n_checks++; if (conf_ready !== 1'b1 || conf_applied !== 1'b0 || act_valid !== 1'b0) begin n_errors++;
      $display("FAIL arst_after got ready=%0d applied=%0d valid=%0d exp 1,0,0", conf_ready, conf_applied, act_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tcfg_t c;
      bit v;
      c.sw = 12'($urandom_range(0, 4095)); c.sh = 12'($urandom_range(0, 4095));
      c.tw = 12'($urandom_range(0, 4095)); c.th = 12'($urandom_range(0, 4095));
      c.iw = 12'($urandom_range(0, 4095)); c.ih = 12'($urandom_range(0, 4095));
      c.ox = 12'($urandom_range(0, 4095)); c.oy = 12'($urandom_range(0, 4095));
      c.sm = 2'($urandom_range(0, 3)); c.bc = 24'($urandom); c.ta = $urandom;
      drv = c;
      en          = ($urandom_range(0, 9) != 0);
      conf_valid  = ($urandom_range(0, 1) != 0);
      frame_start = ($urandom_range(0, 6) == 0);
      step();
      v = m_valid ? exp_vis(m_act) : 1'b0;
      n_checks++; if (act_all !== m_act) begin n_errors++; $display("FAIL rnd_act cyc %0d got=%h exp=%h", i, act_all, m_act); end
      n_checks++; if (act_visible !== v) begin n_errors++; $display("FAIL rnd_vis cyc %0d got=%0d exp=%0d", i, act_visible, v); end
      if (m_valid) begin
        n_checks++; if (act_win_end_x !== exp_end(int'(m_act.ox), int'(m_act.iw), int'(m_act.sw), v) ||
                        act_win_end_y !== exp_end(int'(m_act.oy), int'(m_act.ih), int'(m_act.sh), v)) begin n_errors++;
          $display("FAIL rnd_end cyc %0d got=%0d,%0d", i, act_win_end_x, act_win_end_y); end
      end
      n_checks++; if (conf_ready !== !m_has_pend) begin n_errors++; $display("FAIL rnd_ready cyc %0d got=%0d exp=%0d", i, conf_ready, !m_has_pend); end
      n_checks++; if (conf_applied !== m_applied || act_valid !== m_valid) begin n_errors++;
        $display("FAIL rnd_flags cyc %0d got applied=%0d valid=%0d exp %0d,%0d", i, conf_applied, act_valid, m_applied, m_valid); end
      n_checks++; if (conf_dropped !== 1'b0) begin n_errors++; $display("FAIL rnd_dropped cyc %0d got=%0d exp=0", i, conf_dropped); end
    end
    en = 1'b1; conf_valid = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_pending_apply();
    test_bypass_and_clip();
    test_hold_while_pending();
    test_enable_and_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dc_mcl_conf_receiver.md
Name: dc_mcl_conf_receiver

Overview:
- Consumer end of the main-control-logic configuration interface (conf_* bundle with conf_valid/conf_ready).
- Accepts one configuration into a pending (shadow) register set. Promotes it to the active register set only at a frame boundary, so the scaler and display pipeline never see a mid-frame change.
- Also derives clipped layer-window bounds and a visibility flag. Sits between the config manager and the scaler/pixel fetch pipeline.

Parameters:
- SCR_SIZE_WIDTH, 12, width of all screen/image dimension and offset fields
- AXI_ARADDR_WIDTH, 32, width of texture base address
- RGB_WIDTH, 24, width of border colour
- SCALE_METHOD_WIDTH, 2, width of scaling-method selector

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- en  in  1  global enable; when low, all state and registers hold
- conf_valid  in  1  config bundle valid
- conf_ready  out  1  receiver can accept a bundle
- conf_screen_width/height  in  SCR_SIZE_WIDTH each  display dims
- conf_tex_width/height  in  SCR_SIZE_WIDTH each  source texture dims
- conf_image_width/height  in  SCR_SIZE_WIDTH each  scaled image dims
- conf_image_offset_x/y  in  SCR_SIZE_WIDTH each  image top-left on screen
- conf_scale_method  in  SCALE_METHOD_WIDTH  scaling method
- conf_border_color  in  RGB_WIDTH  border colour
- conf_tex_address  in  AXI_ARADDR_WIDTH  texture base address
- frame_start  in  1  single-cycle pulse at start of vertical blanking
- act_*  out  same widths as the 11 conf_* data fields  active configuration, one output per field
- act_win_end_x/act_win_end_y  out  SCR_SIZE_WIDTH each  clipped exclusive window end
- act_visible  out  1  image overlaps screen
- act_valid  out  1  at least one configuration has been applied since reset
- conf_applied  out  1  one-cycle pulse when the active set updates
- conf_dropped  out  1  sticky; set if frame_start arrives while a transfer is pending but not yet complete (diagnostic, cleared only by reset)

Behaviour:
- Reset values: all act_* = 0, act_valid = 0, act_visible = 0, conf_applied = 0, conf_dropped = 0, conf_ready = 1, FSM = EMPTY, pending registers = 0.
- Handshake: a transfer occurs on a rising clk edge with en=1 && conf_valid && conf_ready. conf_ready is registered and equals (state==EMPTY).
- FSM state EMPTY:
  - Transfer without frame_start: capture bundle into pending; go to PENDING; conf_ready=0 next cycle.
  - Transfer with frame_start in the same cycle: bypass, loading the bundle straight into active; stay EMPTY.
  - frame_start with no transfer: no change to active.
- FSM state PENDING:
  - On frame_start: copy pending to active, pulse conf_applied, set act_valid=1, go to EMPTY (conf_ready=1 next cycle).
  - conf_valid is ignored while in PENDING.
- Latency: act_* change on the clk edge that samples frame_start. conf_applied is high for exactly that following cycle.
- conf_dropped: set when frame_start arrives in EMPTY while conf_valid=1 and conf_ready=0. This cannot happen in normal flow; it guards the en-toggle corner case.
- Window arithmetic, computed on the loaded values with SCR_SIZE_WIDTH+1-bit sums:
  - end_x = min(offset_x + image_width, screen_width); end_y likewise with offset_y, image_height, screen_height.
  - visible = (offset_x < screen_width) && (offset_y < screen_height) && image_width != 0 && image_height != 0.
  - When visible=0, end_x = screen_width and end_y = screen_height.
- en=0: FSM, pending and active sets hold. frame_start and conf_valid are ignored. conf_applied=0.
- Asynchronous reset mid-transfer or mid-pending discards pending data and returns to reset values immediately.

Decomposition:
- dc_mcl_pkg holds:
  - conf_t packed struct of the 11 conf_* data fields, parameterised by the widths above via localparams
  - receiver state enum (EMPTY=1'b0, PENDING=1'b1)
- One sub-module, dc_mcl_conf_window_calc: purely combinational clip/visibility computation, instantiated once on the bypass/pending mux output.

Test Plan:
Settings for all scenarios: SCR_SIZE_WIDTH=12, screen 1280x720, tex 320x240.
- Reset, then idle 10 cycles -> conf_ready=1, act_valid=0, all act_*=0, no conf_applied.
- Transfer image 640x480 at offset (320,120), frame_start 5 cycles later -> conf_ready low for those cycles; act_image_width=640 one cycle after frame_start; act_win_end=(960,600); act_visible=1; conf_applied single pulse; conf_ready=1 again.
- Transfer coincident with frame_start, image 1280x720 at offset (0,0) -> bypass: act_* updated next edge, end=(1280,720), FSM stays EMPTY, conf_ready never drops.
- Offset (1600,1200) with image 320x240 -> act_visible=0, act_win_end=(1280,720). Offset (1100,600) with image 640x480 -> end clipped to (1280,720), visible=1.
- Second conf_valid held while PENDING -> ignored; active gets the first bundle at frame_start; the second is accepted on the cycle after conf_ready returns.
- en=0 across a frame_start while PENDING -> no apply, no conf_applied. Assert nrst mid-PENDING -> all outputs to reset values asynchronously, conf_ready=1 after release.
